// File: rtl/psum_acc_ctrl_pkg.sv
// Shared types and constants for the psum accumulation controller.
package psum_acc_ctrl_pkg;

    // Adder-tree depth: psum0/1 -> psum2 -> out_r.
    localparam int ADD_TREE_LAT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

endpackage

// File: rtl/psum_acc_ctrl_if.sv
// PE-array, psum-FIFO and downstream handshake signals of the psum controller.
interface psum_acc_ctrl_if;

    logic pe_en;
    logic pe_valid;
    logic stall;
    logic fifo_zero;
    logic fifo_rd_en;
    logic fifo_empty;
    logic fifo_wr_en;
    logic fifo_full;
    logic out_valid;
    logic out_ready;

    modport master (
        output pe_en, stall, fifo_zero, fifo_rd_en, fifo_wr_en, out_valid,
        input  pe_valid, fifo_empty, fifo_full, out_ready
    );

    modport slave (
        input  pe_en, stall, fifo_zero, fifo_rd_en, fifo_wr_en, out_valid,
        output pe_valid, fifo_empty, fifo_full, out_ready
    );

endinterface

// File: rtl/psum_tag_pipe.sv
// Stall-gated tag shift register tracking beats through the 3-stage adder tree.
module psum_tag_pipe
    import psum_acc_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  tag_t tag_in,
    output tag_t v1,
    output tag_t v2,
    output tag_t v3
);

    tag_t [ADD_TREE_LAT-1:0] stage;

    // NOTE: the tags are control state, so unlike the adder datapath they take
    // the async reset; a stale valid bit after reset would fake a result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else if (!stall) begin
            // NOTE: non-blocking so every stage shifts from its pre-edge value.
            stage <= {stage[ADD_TREE_LAT-2:0], tag_in};
        end
    end

    assign v1 = stage[0];
    assign v2 = stage[1];
    assign v3 = stage[2];

endmodule

// File: rtl/psum_acc_ctrl.sv
// psum_acc_ctrl: sequences multi-pass psum accumulation for one output row.
// The stall_cnt performance counter is built only when PSUM_CTRL_PERF_EN is defined.
module psum_acc_ctrl
    import psum_acc_ctrl_pkg::*;
#(
    parameter int LEN_W  = 10,
    parameter int PASS_W = 8,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [LEN_W-1:0]  cfg_row_len,
    input  logic [PASS_W-1:0] cfg_num_pass,
    output logic              busy,
    output logic              done,
    psum_acc_ctrl_if.master   bus,
    output logic [PERF_W-1:0] stall_cnt
);

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  row_len_q, col_cnt;
    logic [PASS_W-1:0] num_pass_q, pass_cnt;
    tag_t              tag_in, v1, v2, v3;
    logic              start_acc, accept, col_wrap, last_pass, stall;
    logic              unused_tag_bits;

    assign start_acc = (state == IDLE) && cfg_start;
    assign col_wrap  = (col_cnt == row_len_q - LEN_W'(1));
    assign last_pass = (pass_cnt == num_pass_q - PASS_W'(1));

    assign stall = (v3.valid &&  v3.last  && !bus.out_ready)
                || (v3.valid && !v3.last  &&  bus.fifo_full)
                || (v2.valid && !v2.first &&  bus.fifo_empty);

    assign bus.pe_en  = (state == RUN) && (row_len_q != '0);
    assign accept     = bus.pe_en && bus.pe_valid && !stall;

    assign tag_in.valid = accept;
    assign tag_in.first = accept && (pass_cnt == '0);
    assign tag_in.last  = accept && last_pass;

    psum_tag_pipe u_tag_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .stall  (stall),
        .tag_in (tag_in),
        .v1     (v1),
        .v2     (v2),
        .v3     (v3)
    );

    // FIFO is show-ahead: its head is summed on the same edge as the pop.
    assign bus.stall      = stall;
    assign bus.fifo_zero  = v2.valid && v2.first;
    assign bus.fifo_rd_en = v2.valid && !v2.first && !stall;
    assign bus.fifo_wr_en = v3.valid && !v3.last && !stall;
    assign bus.out_valid  = v3.valid && v3.last;
    assign busy           = (state != IDLE);

    assign unused_tag_bits = ^{v1.first, v1.last, v3.first};

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt
        // unassigned, which would infer a latch.
        state_nxt = state;
        case (state)
            IDLE:  if (cfg_start) state_nxt = RUN;
            RUN: begin
                if (row_len_q == '0)
                    state_nxt = IDLE;
                else if (accept && col_wrap && last_pass)
                    state_nxt = DRAIN;
            end
            // Leave once the final result in out_r is consumed this edge.
            DRAIN: if (!v1.valid && !v2.valid && !(v3.valid && stall))
                state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            done       <= 1'b0;
            row_len_q  <= '0;
            num_pass_q <= '0;
            col_cnt    <= '0;
            pass_cnt   <= '0;
        end else begin
            state <= state_nxt;
            done  <= (state != IDLE) && (state_nxt == IDLE);
            if (start_acc) begin
                row_len_q  <= cfg_row_len;
                num_pass_q <= (cfg_num_pass == '0) ? PASS_W'(1) : cfg_num_pass;
                col_cnt    <= '0;
                pass_cnt   <= '0;
            end else if (accept) begin
                if (col_wrap) begin
                    col_cnt  <= '0;
                    pass_cnt <= pass_cnt + PASS_W'(1);
                end else begin
                    col_cnt  <= col_cnt + LEN_W'(1);
                end
            end
        end
    end

`ifdef PSUM_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (start_acc)
            stall_cnt <= '0;
        else if (busy && stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + PERF_W'(1);
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Self-checking bench for psum_acc_ctrl: job table plus a mid-job reset sequence,
// with a behavioural adder tree and psum FIFO around the controller.
`timescale 1ns/1ps
module tb_psum_acc_ctrl;

    localparam int LEN_W  = 10;
    localparam int PASS_W = 8;
    localparam int PERF_W = 32;
    localparam int FIFO_DEPTH = 8;

    typedef struct {
        int row_len;
        int num_pass;
        int ready_hold;
        int empty_hold;
        int start_busy;
        int exp_outs;
        int exp_push;
        int exp_pop;
        int exp_zero;
        int exp_stall;
    } job_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_start;
    logic [LEN_W-1:0]  cfg_row_len;
    logic [PASS_W-1:0] cfg_num_pass;
    logic              busy, done;
    logic [PERF_W-1:0] stall_cnt;

    psum_acc_ctrl_if bus_if();

    psum_acc_ctrl #(.LEN_W(LEN_W), .PASS_W(PASS_W), .PERF_W(PERF_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_row_len  (cfg_row_len),
        .cfg_num_pass (cfg_num_pass),
        .busy         (busy),
        .done         (done),
        .bus          (bus_if),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural adder tree and show-ahead psum FIFO.
    int         pe_d [4];
    int         p1, p2, out_r;
    int         fifo_mem [16];
    logic [3:0] wr_ptr, rd_ptr;
    int         fifo_cnt;
    logic       force_empty;
    int         sb [$];
    int         n_tests = 0;
    int         n_fail  = 0;

    assign bus_if.fifo_empty = (fifo_cnt == 0) || force_empty;
    assign bus_if.fifo_full  = (fifo_cnt >= FIFO_DEPTH);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1 <= 0; p2 <= 0; out_r <= 0;
            wr_ptr <= '0; rd_ptr <= '0; fifo_cnt <= 0;
        end else begin
            if (!bus_if.stall) begin
                p1    <= pe_d[0] + pe_d[1] + pe_d[2] + pe_d[3];
                p2    <= p1;
                out_r <= p2 + (bus_if.fifo_zero ? 0 : fifo_mem[rd_ptr]);
            end
            if (bus_if.fifo_wr_en) begin
                fifo_mem[wr_ptr] <= out_r;
                wr_ptr <= wr_ptr + 4'd1;
            end
            if (bus_if.fifo_rd_en) rd_ptr <= rd_ptr + 4'd1;
            fifo_cnt <= fifo_cnt + int'(bus_if.fifo_wr_en) - int'(bus_if.fifo_rd_en);
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pe_val(input int p, input int c, input int k);
        return (p + 1) * 1000 + c * 16 + k * 3 + 1;
    endfunction

    function automatic int exp_sum(input int np, input int c);
        int s = 0;
        for (int p = 0; p < np; p++)
            for (int k = 0; k < 4; k++) s += pe_val(p, c, k);
        return s;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_done"},       done, 0);
        check({tag, "_pe_en"},      bus_if.pe_en, 0);
        check({tag, "_stall"},      bus_if.stall, 0);
        check({tag, "_fifo_zero"},  bus_if.fifo_zero, 0);
        check({tag, "_fifo_rd_en"}, bus_if.fifo_rd_en, 0);
        check({tag, "_fifo_wr_en"}, bus_if.fifo_wr_en, 0);
        check({tag, "_out_valid"},  bus_if.out_valid, 0);
        check({tag, "_stall_cnt"},  stall_cnt, 0);
    endtask

    task automatic run_job(input job_t j, input int abort_after);
        int np, pass_i, col_i, accepts, outs, pushes, pops, zeros, stalls;
        int first_acc, first_res, last_out, done_cyc, hold_left, p1_cyc, exp_sc, got;
        bit hold_armed, finished, busy_at_done;
        np = (j.num_pass == 0) ? 1 : j.num_pass;
        pass_i = 0; col_i = 0; accepts = 0; outs = 0; pushes = 0; pops = 0;
        zeros = 0; stalls = 0; hold_left = 0;
        first_acc = -1; first_res = -1; last_out = -1; done_cyc = -1; p1_cyc = -1;
        hold_armed = (j.ready_hold > 0); finished = 0; busy_at_done = 1;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            @(negedge clk);
            cfg_start    = (cyc == 0) || (j.start_busy != 0 && cyc == 3);
            cfg_row_len  = (cyc == 0) ? LEN_W'(j.row_len)   : LEN_W'(1);
            cfg_num_pass = (cyc == 0) ? PASS_W'(j.num_pass) : PASS_W'(7);
            for (int k = 0; k < 4; k++) pe_d[k] = pe_val(pass_i, col_i, k);
            bus_if.pe_valid = 1'b1;
            if (hold_armed && bus_if.out_valid) begin
                hold_left  = j.ready_hold;
                hold_armed = 0;
            end
            bus_if.out_ready = (hold_left == 0);
            force_empty = (p1_cyc >= 0) && (cyc >= p1_cyc + 2) && (cyc < p1_cyc + 2 + j.empty_hold);
            #1;
            if (bus_if.stall) stalls++;
            if (force_empty) begin
                check("empty_stall", bus_if.stall, 1);
                check("empty_no_pop", bus_if.fifo_rd_en, 0);
            end
            if (!bus_if.out_ready) check("ready_stall", bus_if.stall, 1);
            if (first_res < 0 && (bus_if.out_valid || bus_if.fifo_wr_en)) first_res = cyc;
            if (bus_if.out_valid && bus_if.out_ready) begin
                outs++;
                last_out = cyc;
                check("out_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    check("out_value", out_r, got);
                end
            end
            if (bus_if.fifo_wr_en) pushes++;
            if (bus_if.fifo_rd_en) pops++;
            if (bus_if.fifo_zero && !bus_if.stall) zeros++;
            if (bus_if.pe_en && bus_if.pe_valid && !bus_if.stall) begin
                accepts++;
                if (first_acc < 0) first_acc = cyc;
                if (pass_i == 1 && col_i == 0) p1_cyc = cyc;
                if (pass_i == np - 1) sb.push_back(exp_sum(np, col_i));
                if (col_i == j.row_len - 1) begin
                    col_i = 0;
                    pass_i++;
                end else begin
                    col_i++;
                end
            end
            if (done) begin
                done_cyc     = cyc;
                busy_at_done = busy;
                finished     = 1;
            end
            if (hold_left > 0) hold_left--;
            if (abort_after > 0 && accepts == abort_after) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midrst");
                sb.delete();
                force_empty = 1'b0;
                cfg_start   = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        check("job_finished", finished, 1);
        check("busy_at_done", busy_at_done, 0);
        @(negedge clk);
        cfg_start = 1'b0;
        #1;
        check("done_pulse_width", done, 0);
        check("accepts", accepts, j.row_len * np);
        check("outs", outs, j.exp_outs);
        check("pushes", pushes, j.exp_push);
        check("pops", pops, j.exp_pop);
        check("zero_beats", zeros, j.exp_zero);
        check("stall_cycles", stalls, j.exp_stall);
        check("sb_drained", sb.size(), 0);
`ifdef PSUM_CTRL_PERF_EN
        exp_sc = j.exp_stall;
`else
        exp_sc = 0;
`endif
        check("stall_cnt", stall_cnt, exp_sc);
        if (j.row_len > 0) begin
            check("latency", first_res - first_acc, 3);
            check("done_after_last_out", done_cyc - last_out, 1);
        end else begin
            check("zero_len_done_cycle", done_cyc, 2);
        end
    endtask

    initial begin
        job_t jobs [7];
        // row_len, num_pass, ready_hold, empty_hold, start_busy,
        // exp_outs, exp_push, exp_pop, exp_zero, exp_stall
        jobs[0] = '{4, 1, 0, 0, 0, 4, 0, 0, 4, 0};
        jobs[1] = '{4, 3, 0, 0, 0, 4, 8, 8, 4, 0};
        jobs[2] = '{4, 3, 5, 0, 0, 4, 8, 8, 4, 5};
        jobs[3] = '{4, 3, 0, 2, 0, 4, 8, 8, 4, 2};
        jobs[4] = '{3, 0, 0, 0, 1, 3, 0, 0, 3, 0};
        jobs[5] = '{0, 5, 0, 0, 0, 0, 0, 0, 0, 0};
        jobs[6] = '{2, 2, 0, 0, 1, 2, 2, 2, 2, 0};

        cfg_start = 1'b0; cfg_row_len = '0; cfg_num_pass = '0;
        bus_if.pe_valid = 1'b0; bus_if.out_ready = 1'b1; force_empty = 1'b0;
        for (int k = 0; k < 4; k++) pe_d[k] = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_job(jobs[i], 0);

        // Reset during pass 1 of a 3-pass job, then a short single-pass job.
        run_job('{4, 3, 0, 0, 0, 4, 8, 8, 4, 0}, 6);
        run_job('{2, 1, 0, 0, 0, 2, 0, 0, 2, 0}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
